// File: rtl/pdnn_ctrl_pkg.sv
// rtl/pdnn_ctrl_pkg.sv - shared FSM encoding, status codes and cycle length for the PDNN controller
package pdnn_ctrl_pkg;

  localparam int CYC_LEN_DEF = 21;
  localparam int PHASE_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE  = 2'b00,
    ST_CONV  = 2'b01,
    ST_LIMIT = 2'b10,
    ST_ABORT = 2'b11
  } status_t;

endpackage

// File: rtl/pdnn_cycle_timer.sv
// rtl/pdnn_cycle_timer.sv - phase counter 1..CYC_LEN with clear/enable and wrap flag
module pdnn_cycle_timer
  import pdnn_ctrl_pkg::*;
#(
  parameter int CYC_LEN = CYC_LEN_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_wrap
);

  logic [PHASE_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == PHASE_W'(CYC_LEN)) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_phase = r_cnt;
  assign o_wrap  = (r_cnt == PHASE_W'(CYC_LEN));

endmodule

// File: rtl/pdnn_iter_ctrl.sv
// rtl/pdnn_iter_ctrl.sv - iteration scheduler for the LVI-PDNN QP solver network
module pdnn_iter_ctrl
  import pdnn_ctrl_pkg::*;
#(
  parameter int CYC_LEN     = CYC_LEN_DEF,
  parameter int ITER_W      = 16,
  parameter int ERR_W       = 16,
  parameter int CHK_TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [ITER_W-1:0]  i_cfg_max_iter,
  input  logic [ERR_W-1:0]   i_cfg_tol,
  input  logic [ERR_W-1:0]   i_err_in,
  input  logic               i_err_valid,
  output logic               o_load_init,
  output logic               o_net_en_n,
  output logic [PHASE_W-1:0] o_phase,
  output logic [ITER_W-1:0]  o_iter_cnt,
  output logic               o_busy,
  output logic               o_done,
  output logic [1:0]         o_status
);

  localparam int WAIT_W = $clog2(CHK_TIMEOUT + 1);

  state_t              r_state;
  status_t             r_status;
  logic [ITER_W-1:0]   r_max_iter;
  logic [ITER_W-1:0]   r_iter;
  logic [ERR_W-1:0]    r_tol;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_load_init;
  logic                r_net_en_n;
  logic                r_busy;
  logic                r_done;

  logic [ITER_W-1:0]   w_limit;
  logic                w_conv;
  logic                w_at_limit;
  logic                w_active;
  logic                w_timeout;
  logic                w_fin;
  status_t             w_fin_st;
  logic                w_run_next;
  logic                w_wrap;
  logic [PHASE_W-1:0]  w_phase;

  // A zero limit still runs one full iteration before the limit check can fire.
  assign w_limit    = (r_max_iter == '0) ? ITER_W'(1) : r_max_iter;
  assign w_conv     = (i_err_in < r_tol);
  assign w_at_limit = (r_iter >= w_limit);
  assign w_active   = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_CHECK);
  assign w_timeout  = (r_wait == WAIT_W'(CHK_TIMEOUT - 1));

  always_comb begin
    w_fin    = 1'b0;
    w_fin_st = ST_NONE;
    if (w_active && i_abort) begin
      w_fin    = 1'b1;
      w_fin_st = ST_ABORT;
    end else if (r_state == S_CHECK) begin
      if (i_err_valid) begin
        if (w_conv) begin
          w_fin    = 1'b1;
          w_fin_st = ST_CONV;
        end else if (w_at_limit) begin
          w_fin    = 1'b1;
          w_fin_st = ST_LIMIT;
        end
      end else if (w_timeout) begin
        w_fin    = 1'b1;
        w_fin_st = ST_ABORT;
      end
    end
  end

  // The timer advances exactly on cycles whose successor is a RUN cycle.
  always_comb begin
    w_run_next = 1'b0;
    if (!i_reset && !w_fin) begin
      case (r_state)
        S_LOAD:  w_run_next = 1'b1;
        S_RUN:   w_run_next = !w_wrap;
        S_CHECK: w_run_next = i_err_valid;
        default: w_run_next = 1'b0;
      endcase
    end
  end

  pdnn_cycle_timer #(
    .CYC_LEN (CYC_LEN)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (!w_run_next),
    .i_en    (w_run_next),
    .o_phase (w_phase),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_status    <= ST_NONE;
      r_max_iter  <= '0;
      r_tol       <= '0;
      r_iter      <= '0;
      r_wait      <= '0;
      r_load_init <= 1'b0;
      r_net_en_n  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_load_init <= 1'b0;
      r_done      <= 1'b0;
      if (w_fin) begin
        r_state    <= S_DONE;
        r_status   <= w_fin_st;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_net_en_n <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_max_iter  <= i_cfg_max_iter;
              r_tol       <= i_cfg_tol;
              r_iter      <= '0;
              r_wait      <= '0;
              r_status    <= ST_NONE;
              r_busy      <= 1'b1;
              r_load_init <= 1'b1;
              r_state     <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_net_en_n <= 1'b0;
            r_state    <= S_RUN;
          end
          S_RUN: begin
            if (w_wrap) begin
              r_iter     <= (&r_iter) ? r_iter : r_iter + 1'b1;
              r_wait     <= '0;
              r_net_en_n <= 1'b1;
              r_state    <= S_CHECK;
            end
          end
          S_CHECK: begin
            // Reaching here with err_valid means neither converged nor at limit.
            if (i_err_valid) begin
              r_wait     <= '0;
              r_net_en_n <= 1'b0;
              r_state    <= S_RUN;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_load_init = r_load_init;
  assign o_net_en_n  = r_net_en_n;
  assign o_phase     = w_phase;
  assign o_iter_cnt  = r_iter;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_status    = r_status;

endmodule

// File: tb/tb_pdnn_iter_ctrl.sv
// tb/tb_pdnn_iter_ctrl.sv - self-checking bench for pdnn_iter_ctrl against a scripted solve model
module tb_pdnn_iter_ctrl;

  localparam int CYC = 21;
  localparam int TO  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] cfg_max_iter;
  logic [15:0] cfg_tol;
  logic [15:0] err_in;
  logic        err_valid;
  logic        load_init;
  logic        net_en_n;
  logic [4:0]  phase;
  logic [15:0] iter_cnt;
  logic        busy;
  logic        done;
  logic [1:0]  status;

  int n_vec = 0;
  int n_err = 0;

  int pl_dly[8];
  int pl_err[8];
  int ab_iter;
  int ab_phase;

  pdnn_iter_ctrl dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_abort        (abort),
    .i_cfg_max_iter (cfg_max_iter),
    .i_cfg_tol      (cfg_tol),
    .i_err_in       (err_in),
    .i_err_valid    (err_valid),
    .o_load_init    (load_init),
    .o_net_en_n     (net_en_n),
    .o_phase        (phase),
    .o_iter_cnt     (iter_cnt),
    .o_busy         (busy),
    .o_done         (done),
    .o_status       (status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_plan(input int dly, input int err);
    for (int i = 0; i < 8; i++) begin
      pl_dly[i] = dly;
      pl_err[i] = err;
    end
    ab_iter  = 0;
    ab_phase = 0;
  endtask

  // Walks one solve cycle by cycle; the expected outcome follows from the plan arrays.
  task automatic run_solve(input int max_iter, input int tol);
    int limit, k, exp_st, exp_it;
    bit fin, cont;
    limit  = (max_iter == 0) ? 1 : max_iter;
    fin    = 0;
    k      = 0;
    exp_st = 0;
    exp_it = 0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 0);
    start        = 1'b1;
    cfg_max_iter = 16'(max_iter);
    cfg_tol      = 16'(tol);
    @(negedge clk);
    start = 1'b0;
    check_eq("load_pulse", 32'(load_init), 1);
    check_eq("load_en_n", 32'(net_en_n), 1);
    check_eq("load_busy", 32'(busy), 1);
    check_eq("load_status", 32'(status), 0);
    check_eq("load_iter", 32'(iter_cnt), 0);
    while (!fin) begin
      for (int p = 1; p <= CYC && !fin; p++) begin
        @(negedge clk);
        check_eq("run_phase", 32'(phase), p);
        check_eq("run_en_n", 32'(net_en_n), 0);
        check_eq("run_load", 32'(load_init), 0);
        check_eq("run_busy", 32'(busy), 1);
        check_eq("run_iter", 32'(iter_cnt), k);
        start     = ($urandom_range(0, 3) == 0);
        err_valid = ($urandom_range(0, 1) == 1);
        err_in    = '0;
        if (k + 1 == ab_iter && p == ab_phase) begin
          abort  = 1'b1;
          fin    = 1;
          exp_st = 3;
          exp_it = k;
        end
      end
      if (!fin) begin
        k++;
        cont = 0;
        for (int w = 0; w < TO && !fin && !cont; w++) begin
          @(negedge clk);
          start     = 1'b0;
          err_valid = 1'b0;
          check_eq("chk_en_n", 32'(net_en_n), 1);
          check_eq("chk_phase", 32'(phase), 0);
          check_eq("chk_iter", 32'(iter_cnt), k);
          check_eq("chk_done", 32'(done), 0);
          if (w == pl_dly[k-1]) begin
            err_valid = 1'b1;
            err_in    = 16'(pl_err[k-1]);
            if (pl_err[k-1] < tol) begin
              fin = 1; exp_st = 1;
            end else if (k >= limit) begin
              fin = 1; exp_st = 2;
            end else begin
              cont = 1;
            end
          end else if (w == TO - 1) begin
            fin = 1; exp_st = 3;
          end
        end
        exp_it = k;
      end
    end
    @(negedge clk);
    abort     = 1'b0;
    start     = 1'b0;
    err_valid = 1'b0;
    check_eq("done_pulse", 32'(done), 1);
    check_eq("done_busy", 32'(busy), 0);
    check_eq("done_status", 32'(status), exp_st);
    check_eq("done_iter", 32'(iter_cnt), exp_it);
    check_eq("done_en_n", 32'(net_en_n), 1);
    check_eq("done_phase", 32'(phase), 0);
    start = ($urandom_range(0, 1) == 1);
    abort = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("idle_done", 32'(done), 0);
    check_eq("idle_busy2", 32'(busy), 0);
    check_eq("idle_load", 32'(load_init), 0);
    check_eq("idle_status", 32'(status), exp_st);
    check_eq("idle_iter", 32'(iter_cnt), exp_it);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int tol, mi;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    cfg_max_iter = '0;
    cfg_tol      = '0;
    err_in       = '0;
    err_valid    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset held three cycles in the middle of RUN
    start        = 1'b1;
    cfg_max_iter = 16'd3;
    cfg_tol      = 16'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_load", 32'(load_init), 0);
    check_eq("rst_en_n", 32'(net_en_n), 1);
    check_eq("rst_phase", 32'(phase), 0);
    check_eq("rst_iter", 32'(iter_cnt), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_status", 32'(status), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("post_rst_done", 32'(done), 0);
      check_eq("post_rst_busy", 32'(busy), 0);
      check_eq("post_rst_en_n", 32'(net_en_n), 1);
    end

    fill_plan(1, 50);
    run_solve(3, 10);
    fill_plan(1, 50);
    pl_err[1] = 9;
    run_solve(3, 10);
    fill_plan(1, 50);
    pl_err[1] = 10;
    run_solve(3, 10);
    fill_plan(99, 50);
    run_solve(3, 10);
    fill_plan(1, 50);
    ab_iter  = 2;
    ab_phase = 7;
    run_solve(5, 10);
    fill_plan(1, 50);
    run_solve(0, 10);

    for (int n = 0; n < 30; n++) begin
      tol = $urandom_range(0, 100);
      mi  = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) begin
        pl_dly[i] = $urandom_range(0, 17);
        case ($urandom_range(0, 3))
          0:       pl_err[i] = (tol > 0) ? tol - 1 : 0;
          1:       pl_err[i] = tol;
          2:       pl_err[i] = tol + 1;
          default: pl_err[i] = $urandom_range(0, 200);
        endcase
      end
      ab_iter  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      ab_phase = $urandom_range(1, CYC);
      run_solve(mi, tol);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pdnn_iter_ctrl.md
Name: pdnn_iter_ctrl

Overview:
- Top-level iteration scheduler for the LVI-PDNN QP solver network.
- Accepts a start/done solve request, pulses the integrator initial-value load, and gates the network stage sequencer with its active-low run enable for whole iterations of CYC_LEN cycles.
- Samples the datapath residual after each iteration. Stops on convergence, iteration limit, residual timeout or abort, and reports status plus iteration count.

Parameters:
- CYC_LEN, 21, clock cycles per network iteration (stage sequencer wrap length).
- ITER_W, 16, width of the iteration counter and limit.
- ERR_W, 16, width of the unsigned residual magnitude and tolerance.
- CHK_TIMEOUT, 15, max cycles to wait for err_valid in CHECK.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  solve request; sampled only in IDLE.
- abort  in  1  terminate current solve.
- cfg_max_iter  in  ITER_W  iteration limit; latched on accepted start; 0 treated as 1.
- cfg_tol  in  ERR_W  convergence tolerance; latched on accepted start.
- err_in  in  ERR_W  residual magnitude from datapath.
- err_valid  in  1  err_in qualifier.
- load_init  out  1  one-cycle pulse loading integrator initial state.
- net_en_n  out  1  active-low run enable to the stage sequencer (0 = run).
- phase  out  5  cycle index within the iteration, 1..CYC_LEN while running, else 0.
- iter_cnt  out  ITER_W  completed iterations.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 none/running, 01 converged, 10 iteration limit, 11 timeout/abort.

Behaviour:
- Reset values: load_init=0, net_en_n=1, phase=0, iter_cnt=0, busy=0, done=0, status=00, FSM=IDLE, latched cfg=0.
- Reset mid-operation returns to IDLE next edge and drops net_en_n to 1 immediately with the registered outputs.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, CHECK, DONE.
- IDLE:
  - start=1 latches cfg, clears iter_cnt and status, sets busy, and goes to LOAD.
  - start in any other state is ignored.
- LOAD: load_init=1 for exactly one cycle, net_en_n=1, then RUN.
- RUN:
  - net_en_n=0.
  - phase counts 1..CYC_LEN, first RUN cycle has phase=1.
  - At phase==CYC_LEN: iter_cnt increments (saturates at all-ones), phase resets to 0, go to CHECK.
- CHECK:
  - net_en_n=1 so the sequencer resets to its idle slot.
  - A wait counter runs from 0.
  - On err_valid:
    - if err_in < cfg_tol, status=01 and go to DONE;
    - else if iter_cnt >= limit, status=10 and go to DONE;
    - else clear the wait counter and go to RUN.
  - Convergence has priority over the limit on the same cycle; equality with cfg_tol is not converged.
  - If the wait counter reaches CHK_TIMEOUT without err_valid, status=11 and go to DONE.
  - err_valid outside CHECK is ignored.
- abort=1 in LOAD/RUN/CHECK: next state DONE, status=11, net_en_n=1. Abort has priority over all other transitions. Abort in IDLE/DONE has no effect.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - status and iter_cnt hold until the next accepted start.
  - A start in DONE is ignored; it must be reasserted in IDLE.
- Latency:
  - start to first net_en_n=0 is 2 cycles.
  - Each iteration is CYC_LEN RUN cycles plus ≥1 CHECK cycle.

Decomposition:
- Shared package pdnn_ctrl_pkg holds:
  - FSM state encoding;
  - status codes ST_NONE/ST_CONV/ST_LIMIT/ST_ABORT;
  - default CYC_LEN=21 (shared with the stage sequencer).
- One natural sub-module, pdnn_cycle_timer: the phase counter with clear/enable inputs and a wrap pulse at CYC_LEN. Everything else stays in a single module.

Test Plan:
- Reset held 3 cycles during RUN → all outputs at reset values next cycle, FSM IDLE, no done pulse.
- start with cfg_max_iter=3, cfg_tol=10, err_in=50 with err_valid 1 cycle into each CHECK:
  - load_init pulses at cycle 1;
  - net_en_n low for 21 cycles per iteration;
  - done with status=10 and iter_cnt=3.
- Same run with err_in=9 in the 2nd CHECK → status=01, iter_cnt=2; also err_in=10 → no convergence.
- err_valid never asserted in CHECK → done 15 cycles after CHECK entry, status=11, iter_cnt=1.
- abort at phase=7 of iteration 2 → DONE next cycle, status=11, iter_cnt=1, net_en_n=1.
- cfg_max_iter=0 → exactly one iteration run, status=10. start pulsed while busy → ignored, no restart.
